// File: rtl/des_mmio_regs_pkg.sv
// des_mmio_pkg: FSM states, read-select codes and status bit positions for des_mmio_regs
package des_mmio_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  localparam logic [1:0] RDSEL_DMEM = 2'b00;
  localparam logic [1:0] RDSEL_LO = 2'b01;
  localparam logic [1:0] RDSEL_HI = 2'b10;
  localparam logic [1:0] RDSEL_STAT = 2'b11;
  localparam int ST_VALID = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_PEND = 2;
  localparam int ST_ERR = 3;
endpackage

// File: rtl/des_mmio_regs_if.sv
// des_mmio_regs_if: launch/completion handshake between the MMIO register block and the DES core
interface des_mmio_regs_if;
  logic [63:0] des_key;
  logic [63:0] des_data;
  logic [63:0] des_out;
  logic        des_start;
  logic        des_done;
  modport master (output des_key, des_data, des_start, input des_done, des_out);
  modport slave (input des_key, des_data, des_start, output des_done, des_out);
endinterface

// File: rtl/des_mmio_regs.sv
// des_mmio_regs: key/data staging, DES core launch with watchdog, and M-stage read mux
module des_mmio_regs
  import des_mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WEUK,
  input  logic        WELK,
  input  logic        WEUD,
  input  logic        WELD,
  input  logic [31:0] writedata_M,
  input  logic [1:0]  RDsel,
  input  logic [31:0] dmem_rd_M,
  output logic [31:0] readdata_M,
  des_mmio_regs_if.master des
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t state, state_n;
  logic [63:0] key_s, data_s, result;
  logic [CW-1:0] cnt;
  logic valid, err, pending, done_ok, abort, finish;
  logic [31:0] status;
  always_comb begin
    done_ok = state == WAIT && des.des_done;
    abort = state == WAIT && !des.des_done && int'(cnt) == TIMEOUT_CYCLES - 1;
    finish = done_ok || abort;
    state_n = state == IDLE ? (WELD ? START : IDLE) :
              state == START ? WAIT :
              finish ? ((pending || WELD) ? START : IDLE) : WAIT;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s <= '0;
      data_s <= '0;
      result <= '0;
      cnt <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      pending <= 1'b0;
      des.des_key <= '0;
      des.des_data <= '0;
      des.des_start <= 1'b0;
    end else begin
      if (WEUK) key_s[63:32] <= writedata_M;
      if (WELK) key_s[31:0] <= writedata_M;
      if (WEUD) data_s[63:32] <= writedata_M;
      if (WELD) data_s[31:0] <= writedata_M;
      if (WELD && state != IDLE) pending <= 1'b1;
      if (state == START) begin
        des.des_key <= key_s;
        des.des_data <= data_s;
        des.des_start <= 1'b1;
        valid <= 1'b0;
        cnt <= '0;
      end
      if (state == WAIT) begin
        des.des_start <= 1'b0;
        cnt <= cnt + 1'b1;
      end
      if (done_ok) begin
        result <= des.des_out;
        valid <= 1'b1;
        err <= 1'b0;
      end
      if (abort) err <= 1'b1;
      if (finish) pending <= 1'b0;
    end
  end
  always_comb begin
    status = '0;
    status[ST_VALID] = valid;
    status[ST_BUSY] = state != IDLE;
    status[ST_PEND] = pending;
    status[ST_ERR] = err;
    readdata_M = RDsel == RDSEL_LO ? result[31:0] :
                 RDsel == RDSEL_HI ? result[63:32] :
                 RDsel == RDSEL_STAT ? status : dmem_rd_M;
  end
endmodule

// File: tb/tb_des_mmio_regs.sv
// tb_des_mmio_regs: two DUTs (default and 8-cycle watchdog) checked per cycle against a transaction model plus literals
module tb_des_mmio_regs;
  localparam logic [63:0] K = 64'h13345779_9BBCDFF1;
  localparam logic [63:0] D = 64'h01234567_89ABCDEF;
  localparam logic [63:0] C = 64'h85E81354_0F0AB405;
  localparam logic [3:0] UK = 4'b1000, LK = 4'b0100, UD = 4'b0010, LD = 4'b0001;
  typedef struct packed {
    logic [63:0] key_s, data_s, result, snap_k, snap_d;
    logic valid, err, pend, busy, arm, infl, start;
    logic [31:0] waited;
  } mdl_t;
  logic clk = 1'b0, reset = 1'b1;
  logic weuk = 1'b0, welk = 1'b0, weud = 1'b0, weld = 1'b0;
  logic [31:0] writedata = '0, dmem = 32'hDEADBEEF, rd0, rd1;
  logic [1:0] rdsel = 2'd0;
  logic p0 = 1'b0, p1 = 1'b0, inj0 = 1'b0, inj1 = 1'b0;
  logic [63:0] o0 = '0, o1 = '0, k0 = '0, d0 = '0, k1 = '0, d1 = '0;
  int c0 = 0, c1 = 0, lat1 = 4;
  int passed = 0, total = 0;
  mdl_t m0, m1;
  des_mmio_regs_if if0();
  des_mmio_regs_if if1();
  assign if0.des_done = p0 | inj0;
  assign if0.des_out = o0;
  assign if1.des_done = p1 | inj1;
  assign if1.des_out = o1;
  des_mmio_regs u0 (
    .clk(clk), .reset(reset), .WEUK(weuk), .WELK(welk), .WEUD(weud), .WELD(weld),
    .writedata_M(writedata), .RDsel(rdsel), .dmem_rd_M(dmem), .readdata_M(rd0), .des(if0)
  );
  des_mmio_regs #(.TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .reset(reset), .WEUK(weuk), .WELK(welk), .WEUD(weud), .WELD(weld),
    .writedata_M(writedata), .RDsel(rdsel), .dmem_rd_M(dmem), .readdata_M(rd1), .des(if1)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [63:0] fake(input logic [63:0] k, input logic [63:0] d);
    return (k == K && d == D) ? C : k ^ d;
  endfunction

  // One clock edge of the register block, seen as launch / wait / finish transactions.
  function automatic mdl_t step(input mdl_t mi, input logic done, input logic [63:0] dout, input int tmo);
    mdl_t m;
    logic fin;
    m = mi;
    fin = 1'b0;
    if (reset) return '0;
    if (m.arm) begin
      m.snap_k = m.key_s;
      m.snap_d = m.data_s;
      m.start = 1'b1;
      m.valid = 1'b0;
      m.infl = 1'b1;
      m.waited = '0;
      m.arm = 1'b0;
    end else begin
      m.start = 1'b0;
      if (m.infl && done) begin
        m.result = dout;
        m.valid = 1'b1;
        m.err = 1'b0;
        fin = 1'b1;
      end else if (m.infl) begin
        m.waited = m.waited + 1;
        if (m.waited == 32'(tmo)) begin
          m.err = 1'b1;
          fin = 1'b1;
        end
      end
    end
    if (m.busy && weld) m.pend = 1'b1;
    if (fin) begin
      m.infl = 1'b0;
      m.arm = m.pend;
      m.busy = m.pend;
      m.pend = 1'b0;
    end else if (!m.busy && weld) begin
      m.busy = 1'b1;
      m.arm = 1'b1;
    end
    if (weuk) m.key_s[63:32] = writedata;
    if (welk) m.key_s[31:0] = writedata;
    if (weud) m.data_s[63:32] = writedata;
    if (weld) m.data_s[31:0] = writedata;
    return m;
  endfunction

  function automatic logic [31:0] exp_rd(input mdl_t m);
    return rdsel == 2'd1 ? m.result[31:0] : rdsel == 2'd2 ? m.result[63:32] :
           rdsel == 2'd3 ? {28'b0, m.err, m.pend, m.busy, m.valid} : dmem;
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, if0.des_done, if0.des_out, 64);
    m1 = step(m1, if1.des_done, if1.des_out, 8);
    #1;
    chk("u0 des_start", 64'(if0.des_start), 64'(m0.start));
    chk("u0 des_key", if0.des_key, m0.snap_k);
    chk("u0 des_data", if0.des_data, m0.snap_d);
    chk("u0 readdata", 64'(rd0), 64'(exp_rd(m0)));
    chk("u1 des_start", 64'(if1.des_start), 64'(m1.start));
    chk("u1 des_key", if1.des_key, m1.snap_k);
    chk("u1 des_data", if1.des_data, m1.snap_d);
    chk("u1 readdata", 64'(rd1), 64'(exp_rd(m1)));
  end

  // Bench DES cores: main answers 16 cycles after des_start, watchdog DUT after lat1 (0 = never).
  always @(negedge clk) begin
    #1;
    p0 = 1'b0;
    p1 = 1'b0;
    if (reset) begin
      c0 = 0;
      c1 = 0;
    end else begin
      if (c0 > 0) begin
        c0--;
        if (c0 == 0) begin
          p0 = 1'b1;
          o0 = fake(k0, d0);
        end
      end
      if (if0.des_start) begin
        c0 = 16;
        k0 = if0.des_key;
        d0 = if0.des_data;
      end
      if (c1 > 0) begin
        c1--;
        if (c1 == 0) begin
          p1 = 1'b1;
          o1 = fake(k1, d1);
        end
      end
      if (if1.des_start && lat1 > 0) begin
        c1 = lat1;
        k1 = if1.des_key;
        d1 = if1.des_data;
      end
    end
  end

  task automatic wr(input logic [3:0] we, input logic [31:0] v);
    {weuk, welk, weud, weld} = we;
    writedata = v;
    @(negedge clk);
    {weuk, welk, weud, weld} = 4'b0;
  endtask

  task automatic look(input logic [1:0] s);
    rdsel = s;
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    look(2'd0); chk("reset dmem", 64'(rd0), 64'hDEADBEEF);
    look(2'd3); chk("reset status", 64'(rd0), 64'h0);
    chk("reset start", 64'(if0.des_start), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wr(UK, 32'h13345779);
    wr(LK, 32'h9BBCDFF1);
    wr(UD, 32'h01234567);
    wr(LD, 32'h89ABCDEF);
    chk("basic start at E0", 64'(if0.des_start), 64'h0);
    look(2'd3); chk("basic status START", 64'(rd0), 64'h2);
    @(negedge clk);
    chk("basic start at E1", 64'(if0.des_start), 64'h1);
    chk("basic snap key", if0.des_key, K);
    chk("basic snap data", if0.des_data, D);
    look(2'd0); chk("dmem while busy", 64'(rd0), 64'hDEADBEEF);
    @(negedge clk);
    chk("basic start at E2", 64'(if0.des_start), 64'h0);
    repeat (17) @(negedge clk);
    look(2'd2); chk("basic result hi", 64'(rd0), 64'h85E81354);
    look(2'd1); chk("basic result lo", 64'(rd0), 64'h0F0AB405);
    look(2'd3); chk("basic status", 64'(rd0), 64'h1);
    chk("wd basic status", 64'(rd1), 64'h1);
    wr(UD, 32'h11111111);
    wr(LD, 32'h22222222);
    repeat (4) @(negedge clk);
    wr(UD, 32'h33333333);
    wr(LD, 32'h44444444);
    look(2'd3); chk("queued status", 64'(rd0), 64'h6);
    look(2'd2); chk("old result while busy", 64'(rd0), 64'h85E81354);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.des_done && n < 40);
    chk("queued done seen", 64'(if0.des_done), 64'h1);
    chk("start at Ed", 64'(if0.des_start), 64'h0);
    look(2'd3); chk("status at Ed", 64'(rd0), 64'h3);
    @(negedge clk);
    chk("relaunch start at Ed+1", 64'(if0.des_start), 64'h1);
    chk("relaunch data", if0.des_data, 64'h33333333_44444444);
    chk("relaunch key", if0.des_key, K);
    repeat (18) @(negedge clk);
    look(2'd2); chk("queued result hi", 64'(rd0), 64'h2007644A);
    look(2'd1); chk("queued result lo", 64'(rd0), 64'hDFF89BB5);
    look(2'd3); chk("queued status", 64'(rd0), 64'h1);
    lat1 = 0;
    wr(LD, 32'h55555555);
    repeat (8) @(negedge clk);
    chk("wd before limit", 64'(rd1), 64'h2);
    @(negedge clk);
    chk("wd abort status", 64'(rd1), 64'h8);
    look(2'd2); chk("wd result kept", 64'(rd1), 64'h2007644A);
    inj1 = 1'b1;
    @(negedge clk);
    inj1 = 1'b0;
    @(negedge clk);
    look(2'd3); chk("wd late done ignored", 64'(rd1), 64'h8);
    repeat (20) @(negedge clk);
    lat1 = 4;
    wr(UD, 32'h01234567);
    wr(LD, 32'h89ABCDEF);
    repeat (3) @(negedge clk);
    wr(UK, 32'hFFFFFFFF);
    chk("iso key held", if0.des_key, K);
    repeat (18) @(negedge clk);
    look(2'd2); chk("iso result hi", 64'(rd0), 64'h85E81354);
    look(2'd1); chk("iso result lo", 64'(rd0), 64'h0F0AB405);
    look(2'd3); chk("wd err cleared", 64'(rd1), 64'h1);
    wr(LD, 32'h66666666);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset start", 64'(if0.des_start), 64'h0);
    look(2'd3); chk("mid reset status", 64'(rd0), 64'h0);
    look(2'd1); chk("mid reset result lo", 64'(rd0), 64'h0);
    look(2'd2); chk("mid reset result hi", 64'(rd0), 64'h0);
    repeat (2) @(negedge clk);
    inj0 = 1'b1;
    @(negedge clk);
    inj0 = 1'b0;
    look(2'd3); chk("late done after reset", 64'(rd0), 64'h0);
    look(2'd0); chk("dmem idle", 64'(rd0), 64'hDEADBEEF);
    chk("wd dmem idle", 64'(rd1), 64'hDEADBEEF);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
